// File: rtl/frac_sad_select_pkg.sv
// Shared constants, candidate indexing and FSM state type for the fractional SAD selector.
package frac_sad_select_pkg;

  localparam int NUM_CAND   = 15;
  localparam int NUM_ROWS   = 5;
  localparam int LINE_SUM_W = 12;
  localparam int H_ROW_W    = 112;
  localparam int F_ROW_W    = 56;

  localparam int ROW_UH = 0;
  localparam int ROW_UQ = 1;
  localparam int ROW_M  = 2;
  localparam int ROW_LQ = 3;
  localparam int ROW_LH = 4;

  localparam int KIND_H = 0;
  localparam int KIND_Q = 1;
  localparam int KIND_F = 2;

  typedef enum logic [1:0] {ACCUM, SEARCH, DONE} state_t;

  function automatic int cand_idx(input int row, input int kind);
    return row * 3 + kind;
  endfunction

endpackage

// File: rtl/frac_sad_select_byte_sum_tree.sv
// Unsigned sum of NBYTES packed bytes; 14 x 255 still fits the 12-bit line-sum width.
module byte_sum_tree
  import frac_sad_select_pkg::*;
#(
  parameter int NBYTES = 14
) (
  input  logic [NBYTES*8-1:0]   bytes,
  output logic [LINE_SUM_W-1:0] sum
);

  always_comb begin
    sum = '0;
    for (int i = 0; i < NBYTES; i++)
      sum = sum + LINE_SUM_W'(bytes[i*8 +: 8]);
  end

endmodule

// File: rtl/frac_sad_select.sv
// Accumulates 15 fractional-candidate SADs over LINES lines, then scans them
// one per cycle and reports the lowest-index minimum.
module frac_sad_select
  import frac_sad_select_pkg::*;
#(
  parameter int LINES = 8,
  parameter int ACC_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [559:0]         diff_h,
  input  logic [559:0]         diff_q,
  input  logic [279:0]         diff_f,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           best_idx,
  output logic [ACC_W-1:0]     best_sad
);

  localparam int CNT_W = (LINES > 1) ? $clog2(LINES) : 1;

  state_t                                 state;
  logic [CNT_W-1:0]                       line_cnt;
  logic [3:0]                             scan_cnt;
  logic [NUM_CAND-1:0][ACC_W-1:0]         acc;
  logic [NUM_CAND-1:0][LINE_SUM_W-1:0]    linesum;

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    logic [LINE_SUM_W-1:0] fsum;

    byte_sum_tree #(.NBYTES(14)) u_h (
      .bytes (diff_h[r*H_ROW_W +: H_ROW_W]),
      .sum   (linesum[cand_idx(r, KIND_H)])
    );
    byte_sum_tree #(.NBYTES(14)) u_q (
      .bytes (diff_q[r*H_ROW_W +: H_ROW_W]),
      .sum   (linesum[cand_idx(r, KIND_Q)])
    );
    byte_sum_tree #(.NBYTES(7)) u_f (
      .bytes (diff_f[r*F_ROW_W +: F_ROW_W]),
      .sum   (fsum)
    );
    // f carries 7 samples; doubling puts it on the same 14-sample scale as h/q
    assign linesum[cand_idx(r, KIND_F)] = fsum << 1;
  end

  assign in_ready = (state == ACCUM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      line_cnt  <= '0;
      scan_cnt  <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      best_idx  <= '0;
      best_sad  <= '0;
    end else begin
      case (state)
        ACCUM: if (in_valid) begin
          // Line 0 overwrites, so stale sums from the last block never leak in
          for (int k = 0; k < NUM_CAND; k++)
            acc[k] <= (line_cnt == '0) ? ACC_W'(linesum[k])
                                       : acc[k] + ACC_W'(linesum[k]);
          if (line_cnt == CNT_W'(LINES - 1)) begin
            line_cnt <= '0;
            scan_cnt <= '0;
            state    <= SEARCH;
          end else begin
            line_cnt <= line_cnt + 1'b1;
          end
        end
        SEARCH: begin
          if (scan_cnt == 4'd0) begin
            best_sad <= acc[0];
            best_idx <= 4'd0;
          end else if (acc[scan_cnt] < best_sad) begin
            best_sad <= acc[scan_cnt];
            best_idx <= scan_cnt;
          end
          if (scan_cnt == 4'(NUM_CAND - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            scan_cnt <= scan_cnt + 4'd1;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_frac_sad_select.sv
// Directed and randomized blocks checked against a per-candidate byte-sum model.
module tb_frac_sad_select;

  localparam int LINES = 8;
  localparam int ACC_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [559:0]     diff_h;
  logic [559:0]     diff_q;
  logic [279:0]     diff_f;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       best_idx;
  logic [ACC_W-1:0] best_sad;

  int checks = 0;
  int fails  = 0;
  longint msad [15];

  frac_sad_select #(.LINES(LINES), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .diff_h(diff_h), .diff_q(diff_q), .diff_f(diff_f),
    .out_valid(out_valid), .out_ready(out_ready),
    .best_idx(best_idx), .best_sad(best_sad)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Byte value for candidate (row, kind) under a stimulus pattern
  function automatic logic [7:0] bval(input int mode, input int r, input int kind);
    case (mode)
      0: return 8'd0;
      1: return (r == 2 && kind == 2) ? 8'd0 : 8'hFF;
      2: return (r == 1 && kind == 0) ? 8'd1 : 8'd2;
      3: return ((r == 2 && kind == 2) || (r == 0 && kind == 0)) ? 8'd1 : 8'd5;
      4: return 8'hFF;
      5: return 8'd1;
      6: return 8'($urandom_range(0, 255));
      default: return 8'($urandom_range(0, 2));
    endcase
  endfunction

  task automatic gen_line(input int mode);
    for (int r = 0; r < 5; r++)
      for (int b = 0; b < 14; b++) begin
        diff_h[r*112 + b*8 +: 8] = bval(mode, r, 0);
        diff_q[r*112 + b*8 +: 8] = bval(mode, r, 1);
        if (b < 7) diff_f[r*56 + b*8 +: 8] = bval(mode, r, 2);
      end
  endtask

  // Model: each candidate's SAD is the plain byte total, f counted twice
  task automatic model_add();
    for (int r = 0; r < 5; r++) begin
      for (int b = 0; b < 14; b++) begin
        msad[r*3 + 0] += diff_h[r*112 + b*8 +: 8];
        msad[r*3 + 1] += diff_q[r*112 + b*8 +: 8];
      end
      for (int b = 0; b < 7; b++) msad[r*3 + 2] += 2 * diff_f[r*56 + b*8 +: 8];
    end
  endtask

  task automatic send_line(input int mode, input bit gaps);
    @(negedge clk);
    if (gaps && $urandom_range(0, 3) == 0) begin
      in_valid = 1'b0;
      gen_line(6);
      @(negedge clk);
    end
    gen_line(mode);
    in_valid = 1'b1;
    chk("in_ready_accum", 32'(in_ready), 32'd1);
    @(posedge clk);
    model_add();
  endtask

  task automatic run_block(input string tag, input int mode, input bit gaps);
    int eidx;
    longint esad;
    for (int k = 0; k < 15; k++) msad[k] = 0;
    for (int l = 0; l < LINES; l++) send_line(mode, gaps);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 1) in_valid = 1'b0;
      if (c == 15) chk({tag, "_early"}, 32'(out_valid), 32'd0);
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    eidx = 0;
    esad = msad[0];
    for (int k = 1; k < 15; k++)
      if (msad[k] < esad) begin esad = msad[k]; eidx = k; end
    chk({tag, "_idx"}, 32'(best_idx), 32'(eidx));
    chk({tag, "_sad"}, 32'(best_sad), 32'(esad));
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk({tag, "_ov_clr"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [3:0]       hold_idx;
    logic [ACC_W-1:0] hold_sad;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    diff_h = '0; diff_q = '0; diff_f = '0;
    #3;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_best_idx", 32'(best_idx), 32'd0);
    chk("rst_best_sad", 32'(best_sad), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_block("zero", 0, 1'b0);      handshake("zero");
    run_block("mf_zero", 1, 1'b0);   handshake("mf_zero");
    run_block("uqh_one", 2, 1'b0);   handshake("uqh_one");
    run_block("f_tie", 3, 1'b0);     handshake("f_tie");
    run_block("max", 4, 1'b0);

    // Hold the result under backpressure while upstream keeps offering lines
    hold_idx = best_idx;
    hold_sad = best_sad;
    gen_line(4);
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_idx", 32'(best_idx), 32'(hold_idx));
      chk("bp_sad", 32'(best_sad), 32'(hold_sad));
    end
    handshake("bp");
    run_block("after_bp", 5, 1'b0);  handshake("after_bp");

    for (int b = 0; b < 3; b++) begin
      run_block("rand", 6, 1'b1);
      for (int w = $urandom_range(0, 3); w > 0; w--) @(negedge clk);
      handshake("rand");
      run_block("rand_tie", 7, 1'b1);
      handshake("rand_tie");
    end

    // Asynchronous reset partway through a block
    for (int l = 0; l < 4; l++) send_line(6, 1'b0);
    #2;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_sad", 32'(best_sad), 32'd0);
    chk("mid_rst_idx", 32'(best_idx), 32'd0);
    chk("mid_rst_ov", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    run_block("post_rst", 3, 1'b0);
    handshake("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/frac_sad_select.md
Name: frac_sad_select

Overview:
- Consumes per-line absolute-difference vectors from the fractional-pixel abs-diff line stage: 5 vertical positions (UH, UQ, M, LQ, LH) × 3 horizontal kinds (h, q, f).
- Accumulates per-candidate SAD over LINES lines of a block.
- Scans the 15 candidate SADs sequentially and reports the minimum-SAD fractional position to the motion-vector refinement stage.

Parameters:
- LINES, 8, number of lines accepted per block.
- ACC_W, 16, accumulator width; must satisfy ACC_W >= 12 + clog2(LINES).

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  a line of diff vectors is present
- in_ready  output  1  block accepts a line (high only in ACCUM)
- diff_h  input  560  {LH_h, LQ_h, M_h, UQ_h, UH_h}; 112 bits each, 14 unsigned bytes
- diff_q  input  560  {LH_q, LQ_q, M_q, UQ_q, UH_q}; 112 bits each, 14 bytes
- diff_f  input  280  {LH_f, LQ_f, M_f, UQ_f, UH_f}; 56 bits each, 7 bytes
- out_valid  output  1  result available; held until out_ready
- out_ready  input  1  consumer takes the result
- best_idx  output  4  winning candidate index 0..14
- best_sad  output  ACC_W  SAD of the winning candidate

Behaviour:
- Reset is asynchronous and active-high; all regs clear immediately on assertion.
- Reset values:
  - state = ACCUM, line_cnt = 0, scan_cnt = 0
  - all 15 accumulators = 0
  - out_valid = 0, best_idx = 0, best_sad = 0
  - in_ready = 1
- Candidate index = row*3 + kind.
  - row: UH=0, UQ=1, M=2, LQ=3, LH=4.
  - kind: h=0, q=1, f=2.
  - Example: M_f = 8.
- Line sum per candidate is the combinational sum of its bytes.
  - h and q: 14 bytes, 12-bit result.
  - f: 7 bytes, then shifted left by 1 to normalise to 14 samples, 12-bit result.
- ACCUM state:
  - A line is accepted when in_valid && in_ready.
  - On acceptance with line_cnt == 0: acc[k] <= linesum[k], overwriting any stale content.
  - On acceptance otherwise: acc[k] <= acc[k] + linesum[k].
  - line_cnt increments per accepted line.
  - On acceptance with line_cnt == LINES-1: line_cnt <= 0, scan_cnt <= 0, state <= SEARCH.
  - When in_valid is low, nothing changes.
- SEARCH state:
  - in_ready = 0; in_valid is ignored.
  - One candidate per cycle.
  - scan_cnt == 0: best_sad <= acc[0], best_idx <= 0.
  - Otherwise: if acc[scan_cnt] < best_sad (strict), best_sad <= acc[scan_cnt] and best_idx <= scan_cnt.
  - Ties resolve to the lowest index.
  - When scan_cnt == 14: state <= DONE, out_valid <= 1.
- Latency: out_valid rises on the 15th clock edge after the edge that accepted the last line.
- DONE state:
  - in_ready = 0.
  - out_valid, best_idx and best_sad are held stable.
  - On out_valid && out_ready: out_valid <= 0, state <= ACCUM.
  - in_ready rises the cycle after the handshake, so no same-cycle accept.
- No overflow is possible given the ACC_W constraint; no saturation logic.
- Reset mid-block discards partial accumulation; the next accepted line is line 0.

Decomposition:
- Shared package:
  - NUM_CAND = 15
  - ROW_UH..ROW_LH and KIND_H/Q/F constants
  - candidate index function
  - state enum {ACCUM, SEARCH, DONE}
  - LINE_SUM_W = 12
- One sub-module: byte_sum_tree.
  - Parameter NBYTES (14 or 7); unsigned adder tree, combinational.
  - Instantiated 15 times.

Test Plan:
- 8 lines with all diffs 0 -> best_idx 0, best_sad 0; out_valid 15 cycles after last accept.
- 8 lines with all bytes 0xFF except M_f = 0 -> best_idx 8, best_sad 0.
- 8 lines with UQ_h bytes = 1 and all other bytes = 2 -> best_idx 3, best_sad 112; other candidates accumulate 224.
- f normalisation tie: M_f bytes = 1, UH_h bytes = 1, all else 5 -> both sums 112; best_idx 0.
- Max value: all 0xFF for 8 lines -> best_sad 28560, best_idx 0, no wrap.
- Backpressure: out_ready low 10 cycles with in_valid high -> out_valid and outputs stable, in_ready 0, no line consumed. After handshake the next block of all-1 bytes -> best_sad 112, independent of the previous block.
- Reset asserted asynchronously after 4 accepted lines -> outputs clear immediately. A following 8-line block yields the same result as from power-up.
